// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the sync generator, pixel generator and game logic.
// Sync pulses are active-low; coordinates are 10-bit.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int   COORD_W     = 10;
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clock-wide pixel tick.
// The tick is combinational from the divider so it lines up with the edge that consumes it.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// Horizontal/vertical raster counters with registered sync, video_on and a
// once-per-frame tick at the start of vertical blanking.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_tick
);

    localparam int LINE_PIXELS = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(LINE_PIXELS - 1);
    localparam coord_t V_LAST   = coord_t'(FRAME_LINES - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_tick_q, frame_tick_d;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .p_tick(tick)
    );

    // Sync and frame tick are decoded from the next-state counters so they
    // update on the same edge as x/y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        hsync_d      = in_window(x_d, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = in_window(y_d, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_tick_d = tick && (x_d == '0) && (y_d == V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;
    assign p_tick     = tick;
    assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: full-size, reduced-geometry and CLK_DIV=2 instances are compared every
// cycle against a reference computed from the number of clock edges since reset.
module tb_vga_sync;

    typedef struct {
        int div;
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
    } geom_t;

    localparam int S_DIV = 4;
    localparam int S_HD = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int D_DIV = 2;
    localparam int D_VD = 8, D_VF = 1, D_VS = 2, D_VB = 2;

    // {hsync, vsync, video_on, p_tick, frame_tick, x, y} while reset is held
    localparam logic [24:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_f, rst_s, rst_d;
    logic       hs_f, vs_f, von_f, pt_f, ft_f;
    logic       hs_s, vs_s, von_s, pt_s, ft_s;
    logic       hs_d, vs_d, von_d, pt_d, ft_d;
    logic [9:0] x_f, y_f, x_s, y_s, x_d, y_d;
    logic [24:0] obs_f, obs_s, obs_d;
    longint     n_f, n_s, n_d;
    geom_t      g_full, g_small, g_d2;
    int         passed = 0;
    int         total  = 0;

    vga_sync u_full (
        .clk(clk), .reset(rst_f), .hsync(hs_f), .vsync(vs_f), .video_on(von_f),
        .p_tick(pt_f), .x(x_f), .y(y_f), .frame_tick(ft_f)
    );

    vga_sync #(
        .CLK_DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .clk(clk), .reset(rst_s), .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
        .p_tick(pt_s), .x(x_s), .y(y_s), .frame_tick(ft_s)
    );

    vga_sync #(
        .CLK_DIV(D_DIV), .V_DISPLAY(D_VD), .V_FRONT(D_VF), .V_SYNC(D_VS), .V_BACK(D_VB)
    ) u_div2 (
        .clk(clk), .reset(rst_d), .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
        .p_tick(pt_d), .x(x_d), .y(y_d), .frame_tick(ft_d)
    );

    assign obs_f = {hs_f, vs_f, von_f, pt_f, ft_f, x_f, y_f};
    assign obs_s = {hs_s, vs_s, von_s, pt_s, ft_s, x_s, y_s};
    assign obs_d = {hs_d, vs_d, von_d, pt_d, ft_d, x_d, y_d};

    // Clock edges seen since each instance left reset
    always @(posedge clk or posedge rst_f) if (rst_f) n_f <= 0; else n_f <= n_f + 1;
    always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else n_s <= n_s + 1;
    always @(posedge clk or posedge rst_d) if (rst_d) n_d <= 0; else n_d <= n_d + 1;

    function automatic geom_t make_geom(input int dv, input int hd, input int hf, input int hs,
                                        input int hb, input int vd, input int vf, input int vs,
                                        input int vb);
        geom_t g;
        g.div = dv; g.hd = hd; g.hf = hf; g.hs = hs; g.hb = hb;
        g.vd = vd; g.vf = vf; g.vs = vs; g.vb = vb;
        return g;
    endfunction

    // Expected outputs after n edges: pixel count is n/div, raster position follows by division
    function automatic logic [24:0] ref_out(input geom_t g, input longint n);
        longint p;
        int     ht, vt, xi, yi;
        logic   hs, vs, von, pt, ft;
        ht  = g.hd + g.hf + g.hs + g.hb;
        vt  = g.vd + g.vf + g.vs + g.vb;
        p   = n / g.div;
        xi  = int'(p % ht);
        yi  = int'((p / ht) % vt);
        pt  = (n % g.div) == (g.div - 1);
        hs  = !((xi >= g.hd + g.hf) && (xi < g.hd + g.hf + g.hs));
        vs  = !((yi >= g.vd + g.vf) && (yi < g.vd + g.vf + g.vs));
        von = (xi < g.hd) && (yi < g.vd);
        ft  = (p > 0) && ((n % g.div) == 0) && (xi == 0) && (yi == g.vd);
        return {hs, vs, von, pt, ft, 10'(xi), 10'(yi)};
    endfunction

    task automatic test_reset();
        logic [24:0] exp;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (obs_f !== RESET_VEC) $display("[TB] FAIL reset_hold: got %h expected %h", obs_f, RESET_VEC);
            else passed++;
        end
        rst_f = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = ref_out(g_full, n_f);
            total++;
            if (obs_f !== exp) $display("[TB] FAIL reset_release n=%0d: got %h expected %h", n_f, obs_f, exp);
            else passed++;
            if (k == 3) begin
                total++;
                if (pt_f !== 1'b1) $display("[TB] FAIL first_ptick: got %b expected 1", pt_f);
                else passed++;
            end
            if (k == 4) begin
                total++;
                if (x_f !== 10'd1) $display("[TB] FAIL first_x_step: got %0d expected 1", x_f);
                else passed++;
            end
        end
    endtask

    task automatic test_hsync();
        logic [24:0] exp;
        logic prev_hs, prev_von;
        int fall_x = -1, rise_x = -1, von_fall_x = -1, von_rise_x = -1, low_ticks = 0;
        prev_hs  = hs_f;
        prev_von = von_f;
        for (int k = 0; k < 3300; k++) begin
            @(negedge clk);
            exp = ref_out(g_full, n_f);
            total++;
            if (obs_f !== exp) $display("[TB] FAIL hsync_line n=%0d: got %h expected %h", n_f, obs_f, exp);
            else passed++;
            if (prev_hs && !hs_f) fall_x = int'(x_f);
            if (!prev_hs && hs_f) rise_x = int'(x_f);
            if (prev_von && !von_f) von_fall_x = int'(x_f);
            if (!prev_von && von_f) von_rise_x = int'(x_f);
            if (pt_f && !hs_f) low_ticks++;
            prev_hs  = hs_f;
            prev_von = von_f;
        end
        total++;
        if (fall_x != 656) $display("[TB] FAIL hsync_fall_x: got %0d expected 656", fall_x);
        else passed++;
        total++;
        if (rise_x != 752) $display("[TB] FAIL hsync_rise_x: got %0d expected 752", rise_x);
        else passed++;
        total++;
        if (low_ticks != 96) $display("[TB] FAIL hsync_low_ticks: got %0d expected 96", low_ticks);
        else passed++;
        total++;
        if (von_fall_x != 640) $display("[TB] FAIL video_off_x: got %0d expected 640", von_fall_x);
        else passed++;
        total++;
        if (von_rise_x != 0) $display("[TB] FAIL video_on_x: got %0d expected 0", von_rise_x);
        else passed++;
    endtask

    task automatic test_frame_wrap();
        logic [24:0] exp;
        longint ft_times[$];
        int ht, vt, frame_clks, vs_ticks = 0;
        longint first_ft;
        ht         = S_HD + S_HF + S_HS + S_HB;
        vt         = S_VD + S_VF + S_VS + S_VB;
        frame_clks = ht * vt * S_DIV;
        first_ft   = longint'(S_VD * ht * S_DIV);
        rst_s = 1'b0;
        for (int k = 0; k < 2 * frame_clks + 50; k++) begin
            @(negedge clk);
            exp = ref_out(g_small, n_s);
            total++;
            if (obs_s !== exp) $display("[TB] FAIL frame_wrap n=%0d: got %h expected %h", n_s, obs_s, exp);
            else passed++;
            if (ft_s) ft_times.push_back(n_s);
            if (pt_s && !vs_s && n_s <= longint'(frame_clks)) vs_ticks++;
        end
        total++;
        if (ft_times.size() != 2) $display("[TB] FAIL frame_tick_count: got %0d expected 2", ft_times.size());
        else passed++;
        if (ft_times.size() >= 2) begin
            total++;
            if (ft_times[0] != first_ft) $display("[TB] FAIL frame_tick_first: got %0d expected %0d", ft_times[0], first_ft);
            else passed++;
            total++;
            if (ft_times[1] - ft_times[0] != longint'(frame_clks))
                $display("[TB] FAIL frame_tick_period: got %0d expected %0d", ft_times[1] - ft_times[0], frame_clks);
            else passed++;
        end
        total++;
        if (vs_ticks != S_VS * ht) $display("[TB] FAIL vsync_low_ticks: got %0d expected %0d", vs_ticks, S_VS * ht);
        else passed++;
    endtask

    task automatic test_mid_frame_reset();
        logic [24:0] exp;
        bit found = 0;
        int run, hold, off;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (x_s == 10'd20 && y_s == 10'd11) found = 1;
        end
        total++;
        if (!found) $display("[TB] FAIL mid_reset_reach: got 0 expected 1");
        else passed++;
        for (int r = 0; r < 6; r++) begin
            if (r > 0) begin
                run = int'($urandom_range(1, 1500));
                repeat (run) @(negedge clk);
            end
            off = int'($urandom_range(1, 3));
            @(posedge clk);
            #(off);
            rst_s = 1'b1;
            #1;
            total++;
            if (obs_s !== RESET_VEC) $display("[TB] FAIL mid_reset_async: got %h expected %h", obs_s, RESET_VEC);
            else passed++;
            hold = int'($urandom_range(1, 4));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                total++;
                if (obs_s !== RESET_VEC) $display("[TB] FAIL mid_reset_hold: got %h expected %h", obs_s, RESET_VEC);
                else passed++;
            end
            rst_s = 1'b0;
            run = (r == 0) ? 220 : int'($urandom_range(20, 200));
            for (int k = 0; k < run; k++) begin
                @(negedge clk);
                exp = ref_out(g_small, n_s);
                total++;
                if (obs_s !== exp) $display("[TB] FAIL mid_reset_restart n=%0d: got %h expected %h", n_s, obs_s, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_div2();
        logic [24:0] exp;
        longint line_starts[$];
        longint last_pt = -1;
        logic [9:0] prev_x;
        logic prev_hs;
        int bad_period = 0, pt_count = 0, fall_x = -1, run = 3300;
        rst_d   = 1'b0;
        prev_x  = x_d;
        prev_hs = hs_d;
        for (int k = 0; k < run; k++) begin
            @(negedge clk);
            exp = ref_out(g_d2, n_d);
            total++;
            if (obs_d !== exp) $display("[TB] FAIL div2_track n=%0d: got %h expected %h", n_d, obs_d, exp);
            else passed++;
            if (pt_d) begin
                pt_count++;
                if (last_pt >= 0 && n_d - last_pt != 2) bad_period++;
                last_pt = n_d;
            end
            if (prev_x == 10'd799 && x_d == 10'd0) line_starts.push_back(n_d);
            if (prev_hs && !hs_d && fall_x < 0) fall_x = int'(x_d);
            prev_x  = x_d;
            prev_hs = hs_d;
        end
        total++;
        if (bad_period != 0 || pt_count != (run + 1) / 2)
            $display("[TB] FAIL div2_ptick: got count=%0d bad=%0d expected count=%0d bad=0", pt_count, bad_period, (run + 1) / 2);
        else passed++;
        total++;
        if (line_starts.size() < 2 || line_starts[1] - line_starts[0] != 64'd1600)
            $display("[TB] FAIL div2_line_len: got %0d starts expected 2 starts 1600 apart", line_starts.size());
        else passed++;
        total++;
        if (fall_x != 656) $display("[TB] FAIL div2_hsync_fall_x: got %0d expected 656", fall_x);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        g_full  = make_geom(4, 640, 16, 96, 48, 480, 10, 2, 33);
        g_small = make_geom(S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
        g_d2    = make_geom(D_DIV, 640, 16, 96, 48, D_VD, D_VF, D_VS, D_VB);
        rst_f = 1'b1;
        rst_s = 1'b1;
        rst_d = 1'b1;
        test_reset();
        test_hsync();
        test_frame_wrap();
        test_mid_frame_reset();
        test_div2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
